// File: rtl/tt_scanner.sv
// Truth-table scanner: walks a 4-input vector through 0..15, samples y_in per vector,
// and optionally compares the captured table against EXPECTED (define TT_SCANNER_COMPARE_EN).
module tt_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h00BF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        mismatch,
    output logic [3:0]  fail_idx
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  idx_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] table_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] table_next;

    // Table as it will look once the current vector's response is merged in.
    for (genvar gi = 0; gi < 16; gi++) begin : g_merge
        assign table_next[gi] = (idx_reg == 4'(gi)) ? y_in : table_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            cnt_reg   <= 4'd0;
            table_reg <= 16'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= SETTLE;
                        idx_reg   <= 4'd0;
                        cnt_reg   <= 4'd0;
                        table_reg <= 16'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_reg <= table_next;
                    if (idx_reg == 4'd15) begin
                        // idx stays at 15 so the last vector remains applied while idle.
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg   <= idx_reg + 4'd1;
                        cnt_reg   <= 4'd0;
                        state_reg <= SETTLE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign table_out    = table_reg;

`ifdef TT_SCANNER_COMPARE_EN
    logic       mismatch_reg;
    logic [3:0] fail_idx_reg;
    logic [15:0] diff;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

    assign diff = table_next ^ EXPECTED;

    // Evaluated on the final sample so the result is valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
            fail_idx_reg <= 4'd0;
        end else if (state_reg == IDLE && start) begin
            mismatch_reg <= 1'b0;
            fail_idx_reg <= 4'd0;
        end else if (state_reg == SAMPLE && idx_reg == 4'd15) begin
            mismatch_reg <= |diff;
            fail_idx_reg <= lowest_set(diff);
        end
    end

    assign mismatch = mismatch_reg;
    assign fail_idx = fail_idx_reg;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign mismatch        = 1'b0;
    assign fail_idx        = 4'd0;
`endif

endmodule

// File: doc/tt_scanner.md
TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the cycles each input vector is held before sampling (legal 1..15).
REQ-002 SHALL have parameter EXPECTED, default 16'h00BF, giving the golden 16-entry truth table; bit k is the output expected for vector k.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-006 SHALL have port a, b, c, d  output  1 each  stimulus to the device under scan; {a,b,c,d} = idx, with a as MSB.
REQ-007 SHALL have port y_in  input  1  response from the device under scan.
REQ-008 SHALL have port busy  output  1  high while in SETTLE or SAMPLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-010 SHALL have port table_out  output  16  captured truth table; bit k is y_in sampled for vector k.
REQ-011 SHALL have port mismatch  output  1  captured table differs from EXPECTED; valid from done onward.
REQ-012 SHALL have port fail_idx  output  4  lowest bit index where table_out and EXPECTED differ.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE with registered outputs.
REQ-014 SHALL, on start=1 in IDLE: move to SETTLE, set idx=0, clear the settle counter, clear table_out, mismatch and fail_idx.
REQ-015 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-016 SHALL, in SAMPLE, write y_in into table_out[idx] at the clock edge.
REQ-017 SHALL, in SAMPLE with idx<15, increment idx and return to SETTLE.
REQ-018 SHALL, in SAMPLE with idx==15, enter DONE with no wrap of idx.
REQ-019 SHALL take SETTLE_CYCLES+1 cycles per vector.
REQ-020 SHALL take 16*(SETTLE_CYCLES+1) busy cycles per scan, followed by 1 DONE cycle.
REQ-021 SHALL assert done only in DONE, then return to IDLE on the next cycle.
REQ-022 SHALL ignore start in SETTLE, SAMPLE and DONE; a new scan needs start=1 while in IDLE.
REQ-023 SHALL hold table_out, mismatch and fail_idx stable in IDLE after a scan until the next accepted start.
REQ-024 SHALL hold a,b,c,d at the last applied vector (4'hF) in IDLE after a scan.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-scan, go immediately to IDLE.
REQ-026 SHALL, on reset, clear idx, the settle counter, a,b,c,d, busy, done, table_out, mismatch and fail_idx to 0.
REQ-027 SHALL produce no done pulse for a scan aborted by reset.

Configuration
REQ-028 SHALL, with TT_SCANNER_COMPARE_EN defined, compute mismatch=(table_out!=EXPECTED) and fail_idx=lowest differing bit.
REQ-029 SHALL, with TT_SCANNER_COMPARE_EN defined, register mismatch and fail_idx on entry to DONE so they are valid in the same cycle as done.
REQ-030 SHALL, with TT_SCANNER_COMPARE_EN undefined, tie mismatch and fail_idx to 0 and synthesize no comparison logic.

Verification
REQ-031 SHALL cover golden DUT y=~a&(~(b&c)|d), SETTLE_CYCLES=2, start pulse at cycle 0 -> done high at cycle 49, table_out=16'h00BF, mismatch=0.
REQ-032 SHALL cover y_in tied 0 with COMPARE_EN defined -> table_out=16'h0000, mismatch=1, fail_idx=0.
REQ-033 SHALL cover golden DUT with bit 6 forced to 1 -> table_out=16'h00FF, mismatch=1, fail_idx=6.
REQ-034 SHALL cover start re-pulsed at cycle 10 -> ignored; exactly one done pulse at cycle 49.
REQ-035 SHALL cover rst pulsed at cycle 20 -> immediate IDLE, all outputs 0, no done; a following start runs a full, correct scan.
REQ-036 SHALL cover SETTLE_CYCLES=1 -> a,b,c,d change every 2 cycles, done at cycle 33.
